// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Iterative restoring divider for the arithmetic unit's divide path. An
// operand pair is accepted on a one-cycle start pulse. The divider then
// resolves one quotient bit per clock, MSB first, using a single WIDTH+1-bit
// trial subtractor. Results are presented together with a one-cycle done
// strobe, and they are held until the next accepted start.
//
// Parameters
//   WIDTH        operand / quotient / remainder width in bits (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (aborts any operation)
//   start        request, accepted only in IDLE or DONE
//   dividend     dividend, sampled on an accepted start
//   divisor      divisor, sampled on an accepted start
//   busy         high while iterating (state RUN)
//   done         one-cycle strobe, results valid from this cycle
//   quotient     quotient, held until the next result or reset
//   remainder    remainder, held until the next result or reset
//   div_by_zero  the held result came from a zero divisor
//
// Build option
//   DIV_SIGNED_EN  when defined, operands are two's complement. Magnitudes
//                  run through the unchanged unsigned core, and signs are
//                  restored on entry to DONE (truncation toward zero). When
//                  undefined, no sign logic is built.
//
// Latency is WIDTH+1 cycles from the start edge to done. A zero divisor is
// not short-circuited: it takes the full latency.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;

    // The partial remainder is always below the divisor after a step, or it
    // equals the dividend prefix when the divisor is zero. Either way it
    // fits in WIDTH bits. Only the shifted value needs the extra bit.
    logic [WIDTH-1:0]   partial;

    // Shared shift register. Dividend bits leave at the top while quotient
    // bits enter at the bottom. After WIDTH steps it holds the quotient.
    logic [WIDTH-1:0]   dq;

    logic [WIDTH-1:0]   divisor_r;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   next_partial;
    logic [WIDTH-1:0]   next_dq;
    logic [WIDTH-1:0]   final_q;
    logic [WIDTH-1:0]   final_r;

    logic [WIDTH-1:0]   load_dividend;
    logic [WIDTH-1:0]   load_divisor;

`ifdef DIV_SIGNED_EN
    logic               neg_q;
    logic               neg_r;
`endif

    // Operand conditioning at accept time. In the signed build the core only
    // ever sees magnitudes. The most-negative value maps onto itself, and
    // read as unsigned that is exactly its magnitude, so no extra bit is
    // needed.
    always_comb begin
        load_dividend = dividend;
        load_divisor  = divisor;
`ifdef DIV_SIGNED_EN
        if (dividend[WIDTH-1]) begin
            load_dividend = -dividend;
        end
        if (divisor[WIDTH-1]) begin
            load_divisor = -divisor;
        end
`endif
    end

    // One restoring step. Shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. A clear borrow (MSB of the
    // trial) means the subtraction fits: keep it and emit a 1. Otherwise
    // restore the shifted value and emit a 0. The final_* values are what
    // gets published when this step is the last one.
    always_comb begin
        shifted      = {partial, dq[WIDTH-1]};
        trial        = shifted - {1'b0, divisor_r};
        qbit         = ~trial[WIDTH];
        next_partial = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_dq      = {dq[WIDTH-2:0], qbit};
        final_q      = next_dq;
        final_r      = next_partial;
`ifdef DIV_SIGNED_EN
        // With a zero divisor the magnitude core yields all ones and the
        // magnitude of the dividend. The quotient keeps all ones whatever
        // the signs are. Re-signing the remainder recovers the original
        // dividend.
        if (divisor_r == '0) begin
            final_q = '1;
        end else if (neg_q) begin
            final_q = -next_dq;
        end
        if (neg_r) begin
            final_r = -next_partial;
        end
`endif
    end

    // Control FSM with registered outputs.
    // In IDLE and DONE a start latches the operands and begins WIDTH
    // iterations. The counter is loaded with WIDTH-1 and the step taken at
    // count 0 is the last one. busy and done are registered here next to
    // the state, so they are never high together. The published results
    // only change on entry to DONE or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            partial     <= '0;
            dq          <= '0;
            divisor_r   <= '0;
            count       <= '0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        partial   <= '0;
                        dq        <= load_dividend;
                        divisor_r <= load_divisor;
                        count     <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                        neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r     <= dividend[WIDTH-1];
`endif
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    partial <= next_partial;
                    dq      <= next_dq;
                    count   <= count - 1'b1;
                    if (count == '0) begin
                        quotient    <= final_q;
                        remainder   <= final_r;
                        div_by_zero <= (divisor_r == '0);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider (WIDTH=8). Expected results come from
// a plain-arithmetic reference model (/ and %, with the zero-divisor rule),
// and the model follows DIV_SIGNED_EN when that macro is defined. Every
// operation is tracked cycle by cycle. The bench checks that busy covers
// exactly WIDTH cycles, that done lands on cycle WIDTH+1, and that the
// published results hold steady until then.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int           checks;
    int           errors;

    logic [W-1:0] held_q;
    logic [W-1:0] held_r;
    logic         held_z;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock with a 10-unit period. Outputs are sampled on the
    // falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so that a hung design still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point. It counts every check and reports any
    // mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: the result of a divide, taken straight from the
    // arithmetic definition.
    function automatic void modelDivide(input logic [W-1:0] a, input logic [W-1:0] b,
                                        output logic [W-1:0] q, output logic [W-1:0] r,
                                        output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        z  = (sb == 0);
        if (sb == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
`else
        int ua;
        int ub;
        ua = int'(a);
        ub = int'(b);
        z  = (ub == 0);
        if (ub == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(ua / ub);
            r = W'(ua % ub);
        end
`endif
    endfunction

    // Idle cycles: no activity, and results are held.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_done", 32'(done), 32'd0);
            checkOutput("idle_quotient", 32'(quotient), 32'(held_q));
            checkOutput("idle_remainder", 32'(remainder), 32'(held_r));
        end
    endtask

    // Runs one operation. The task is called at a falling edge. It drives
    // start for one clock edge and then tracks every cycle up to done. If
    // injectAt is non-zero, a stray start (9/2) is pulsed during that busy
    // cycle, and the operation in flight must ignore it. The task returns at
    // the falling edge of the done cycle, so an immediate second call is
    // back-to-back.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int injectAt);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        modelDivide(a, b, eq, er, ez);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            checkOutput("run_busy", 32'(busy), 32'd1);
            checkOutput("run_done", 32'(done), 32'd0);
            checkOutput("run_hold_q", 32'(quotient), 32'(held_q));
            checkOutput("run_hold_r", 32'(remainder), 32'(held_r));
            checkOutput("run_hold_z", 32'(div_by_zero), 32'(held_z));
            if (i == injectAt) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd2;
                @(posedge clk);
                #1;
                start    = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("done_strobe", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("quotient", 32'(quotient), 32'(eq));
        checkOutput("remainder", 32'(remainder), 32'(er));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(ez));
        held_q = eq;
        held_r = er;
        held_z = ez;
    endtask

    // Main sequence: directed cases first, then randomized traffic.
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks   = 0;
        errors   = 0;
        held_q   = '0;
        held_r   = '0;
        held_z   = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] directed: basic, zero divisor, back-to-back");
        applyStimulus(8'd200, 8'd7, 0);
        idleCycles(2);
        applyStimulus(8'd5, 8'd0, 0);
        idleCycles(1);
        applyStimulus(8'd0, 8'd3, 0);
        idleCycles(1);
        applyStimulus(8'd255, 8'd1, 0);
        applyStimulus(8'd255, 8'd255, 0);
        idleCycles(2);

        $display("[TB] directed: start during RUN is ignored");
        applyStimulus(8'd100, 8'd10, 3);
        idleCycles(12);

        $display("[TB] directed: reset mid-run");
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_quotient", 32'(quotient), 32'd0);
        checkOutput("midreset_remainder", 32'(remainder), 32'd0);
        checkOutput("midreset_dbz", 32'(div_by_zero), 32'd0);
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        idleCycles(2);
        applyStimulus(8'd17, 8'd5, 0);
        idleCycles(1);

        $display("[TB] directed: sign-sensitive patterns");
        applyStimulus(8'h9C, 8'd7, 0);
        applyStimulus(8'h80, 8'hFF, 0);
        applyStimulus(8'h80, 8'h00, 0);
        idleCycles(1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rb = W'($urandom_range(1, 4));
            end
            applyStimulus(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0);
            if ($urandom_range(0, 1) == 1) begin
                idleCycles(int'($urandom_range(1, 3)));
            end
        end
        idleCycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider: the inverse datapath to the Dadda multiplier and carry-select adders. Accepts an unsigned dividend/divisor pair on a one-cycle start pulse and resolves one quotient bit per clock using a single WIDTH+1-bit trial subtractor. Results are presented with a one-cycle done strobe. Sits beside the multiplier as the arithmetic unit's divide path.

## Interface
- WIDTH, 8, operand/quotient/remainder width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when state is IDLE or DONE
- dividend  input  WIDTH  dividend, sampled on accepted start
- divisor  input  WIDTH  divisor, sampled on accepted start
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle strobe; results valid from this cycle
- quotient  output  WIDTH  quotient, held until next accepted start
- remainder  output  WIDTH  remainder, held until next accepted start
- div_by_zero  output  1  divisor was zero for the held result

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + start=1: latch operands; clear partial remainder (WIDTH+1 bits) and quotient; load iteration counter with WIDTH-1; -> RUN. Any other input in IDLE: stay. DONE without start -> IDLE.
- RUN, each cycle: partial = {partial[WIDTH-1:0], next dividend bit, MSB first}; trial = partial - {1'b0, divisor}; if trial >= 0 (trial MSB = 0) keep trial and shift in quotient bit 1, else keep partial and shift in 0. Counter decrements; on the counter = 0 step -> DONE.
- DONE: done=1, quotient/remainder/div_by_zero valid; busy=0.
- start while RUN: ignored, no effect on the operation in flight.
- Divisor = 0: no short-circuit; full latency; quotient = all ones, remainder = dividend (natural restoring result); div_by_zero=1.
- Remainder always < divisor when divisor != 0; dividend = quotient*divisor + remainder.
- Reset in any state: abort, -> IDLE, all outputs cleared on the next edge.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- start sampled high at edge k: busy=1 in cycles k+1 .. k+WIDTH; done=1 exactly in cycle k+WIDTH+1; latency WIDTH+1 cycles.
- Back-to-back: start during the done cycle is accepted; busy rises the next cycle, done falls; throughput one result per WIDTH+1 cycles.
- quotient/remainder/div_by_zero change only on the transition into DONE or on reset; stable otherwise.
- done and busy never high in the same cycle.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement. On accept, magnitudes are latched and sign flags stored; the unsigned core runs unchanged; in the entry to DONE, quotient negated if operand signs differ, remainder negated if dividend negative (truncation toward zero). Most-negative / -1 returns quotient = most-negative (wrap), remainder 0. Divide-by-zero: quotient all ones, remainder = dividend. Latency unchanged.
- DIV_SIGNED_EN undefined: purely unsigned as above; no sign logic synthesized.

## Test plan
- WIDTH=8, start with 200/7 at edge k -> busy k+1..k+8, done at k+9, quotient=28, remainder=4, div_by_zero=0.
- 5/0 -> quotient=255, remainder=5, div_by_zero=1, same 9-cycle latency; then 0/3 -> quotient=0, remainder=0, div_by_zero=0.
- 255/1 then back-to-back start in the done cycle with 255/255 -> 255/0 then 1/0, second done exactly 9 cycles after the first.
- start pulsed with 9/2 at cycle k+3 of a running 100/10 -> ignored; result 10/0, no second done.
- rst asserted mid-RUN -> next cycle busy=0, done=0, all outputs 0; new start 17/5 -> 3/2 after 9 cycles.
- DIV_SIGNED_EN: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); -128/-1 -> quotient=0x80, remainder=0.
